// File: rtl/fp_minmax_reduce_if.sv
// Stream interface for fp_minmax_reduce: element input stream and result output.
// master = element producer / result consumer, slave = the reduction block.
interface fp_minmax_reduce_if #(
  parameter int W     = 32,
  parameter int IDX_W = 16
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_nan;

  modport master (
    output mode, in_valid, in_first, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_nan
  );

  modport slave (
    input  mode, in_valid, in_first, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_nan
  );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction with first-occurrence index over IEEE-754-style values.
// Define FP_MINMAX_NAN_EN to make NaNs lose to every non-NaN and report all-NaN vectors.
module fp_minmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int IDX_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  fp_minmax_reduce_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q;
  logic [W-1:0]     acc_q,  acc_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic [IDX_W-1:0] cnt_q,  cnt_d;
  logic             mode_q, mode_d;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             in_ready;
  logic             accept;
  logic             start;
  logic             new_wins;

  // Unsigned key: positives above negatives, negatives reversed, so -0 < +0.
  function automatic logic [W-1:0] ord_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : {1'b1, x[W-2:0]};
  endfunction

`ifdef FP_MINMAX_NAN_EN
  logic acc_nan_q, acc_nan_d;
  logic out_nan_q;
  logic new_nan;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  assign new_nan     = is_nan(bus.in_data);
  assign bus.out_nan = out_nan_q;
`else
  assign bus.out_nan = 1'b0;
`endif

  assign in_ready      = rstn && (state_q != DONE || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  // Any beat outside an open vector starts a new one regardless of in_first.
  assign start         = accept && (state_q != ACC || bus.in_first);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

  always_comb begin
    new_wins = 1'b0;
`ifdef FP_MINMAX_NAN_EN
    if (new_nan)
      new_wins = 1'b0;
    else if (acc_nan_q)
      new_wins = 1'b1;
    else
`endif
    if (mode_q)
      new_wins = ord_key(bus.in_data) > ord_key(acc_q);
    else
      new_wins = ord_key(bus.in_data) < ord_key(acc_q);
  end

  always_comb begin
    acc_d  = acc_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
`ifdef FP_MINMAX_NAN_EN
    acc_nan_d = acc_nan_q;
`endif
    if (start) begin
      acc_d  = bus.in_data;
      idx_d  = '0;
      cnt_d  = IDX_W'(1);
      mode_d = bus.mode;
`ifdef FP_MINMAX_NAN_EN
      acc_nan_d = new_nan;
`endif
    end else if (accept) begin
      if (new_wins) begin
        acc_d = bus.in_data;
        idx_d = cnt_q;
`ifdef FP_MINMAX_NAN_EN
        acc_nan_d = new_nan;
`endif
      end
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
`ifdef FP_MINMAX_NAN_EN
      acc_nan_q   <= 1'b0;
      out_nan_q   <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
`ifdef FP_MINMAX_NAN_EN
      acc_nan_q <= acc_nan_d;
`endif
      if (accept) begin
        if (bus.in_last) begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_d;
          out_idx_q   <= idx_d;
`ifdef FP_MINMAX_NAN_EN
          // The accumulator stays NaN only when every element was NaN.
          out_nan_q <= acc_nan_d;
          if (acc_nan_d) begin
            out_data_q <= CANON_NAN;
            out_idx_q  <= '0;
          end
`endif
        end else begin
          state_q     <= ACC;
          out_valid_q <= 1'b0;
        end
      end else if (state_q == DONE && bus.out_ready) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed self-checking bench for fp_minmax_reduce; expectations follow FP_MINMAX_NAN_EN.
module tb_fp_minmax_reduce;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_minmax_reduce_if #(.W(32), .IDX_W(16)) bus ();

  fp_minmax_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic f, input logic l, input logic m);
    int n;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_last  = l;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] ed, input logic [15:0] ei,
                            input logic en);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, bus.out_data, ed);
    chk({tag, "_idx"}, 32'(bus.out_idx), 32'(ei));
    chk({tag, "_nan"}, 32'(bus.out_nan), 32'(en));
    $display("result %s: data=%h idx=%0d nan=%0d", tag, bus.out_data, bus.out_idx, bus.out_nan);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset state, with in_valid and out_ready high to prove in_ready stays low.
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_nan", 32'(bus.out_nan), 32'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic min and max.
    send(32'h3F800000, 1, 0, 0);
    chk("acc_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'hC0000000, 0, 0, 0);
    send(32'h40400000, 0, 1, 0);
    get_result("min3", 32'hC0000000, 16'd1, 1'b0);
    send(32'h3F800000, 1, 0, 1);
    send(32'hC0000000, 0, 0, 1);
    send(32'h40400000, 0, 1, 1);
    get_result("max3", 32'h40400000, 16'd2, 1'b0);

    // Signed zeros and ties.
    send(32'h00000000, 1, 0, 0);
    send(32'h80000000, 0, 1, 0);
    get_result("min_zero", 32'h80000000, 16'd1, 1'b0);
    send(32'h00000000, 1, 0, 1);
    send(32'h80000000, 0, 1, 1);
    get_result("max_zero", 32'h00000000, 16'd0, 1'b0);
    send(32'h40000000, 1, 0, 0);
    send(32'h40000000, 0, 1, 0);
    get_result("min_tie", 32'h40000000, 16'd0, 1'b0);

    // Mode is latched on the first beat, and in_first mid-vector restarts.
    send(32'h41000000, 1, 0, 1);
    send(32'h3F800000, 1, 0, 1);
    send(32'h40400000, 0, 0, 0);
    send(32'h40000000, 0, 1, 0);
    get_result("restart_max", 32'h40400000, 16'd1, 1'b0);

    // Back-to-back with output held for 5 cycles.
    send(32'h3F800000, 1, 0, 1);
    send(32'h40000000, 0, 1, 1);
    held = bus.out_data;
    chk("hold_first_data", held, 32'h40000000);
    bus.in_data = 32'h3F800000; bus.in_first = 1'b1; bus.in_last = 1'b1;
    bus.mode = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, 32'h40000000);
      chk("hold_idx", 32'(bus.out_idx), 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    get_result("b2b_second", 32'h3F800000, 16'd0, 1'b0);
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a vector.
    send(32'h40A00000, 1, 0, 0);
    send(32'h3F000000, 0, 0, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid_after", 32'(bus.out_valid), 32'd0);
    send(32'h40A00000, 0, 0, 0);
    send(32'h3F800000, 0, 0, 0);
    send(32'h40000000, 0, 1, 0);
    get_result("after_rst", 32'h3F800000, 16'd1, 1'b0);

`ifdef FP_MINMAX_NAN_EN
    send(32'h7FC00000, 1, 0, 0);
    send(32'h3F800000, 0, 1, 0);
    get_result("nan_first", 32'h3F800000, 16'd1, 1'b0);
    send(32'h7FC00001, 1, 0, 0);
    send(32'hFFC00000, 0, 1, 0);
    get_result("nan_all", 32'h7FC00000, 16'd0, 1'b1);
`else
    send(32'h3F800000, 1, 0, 1);
    send(32'h7FC00000, 0, 1, 1);
    get_result("nan_raw", 32'h7FC00000, 16'd1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
